bp_update_sched: RTL and testbench
==================================

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, update-queue depth (power of two, >=2).
REQ-002 SHALL have parameter CNTW, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global ready; when low all state holds and no handshake completes.
REQ-006 SHALL have port ex_valid  input  1  EX stage presents a resolved control-flow instruction.
REQ-007 SHALL have port ex_is_btype  input  1  the instruction is a conditional branch.
REQ-008 SHALL have port ex_taken  input  1  actual branch outcome.
REQ-009 SHALL have port ex_pred_taken  input  1  outcome predicted at IF.
REQ-010 SHALL have port ex_pc  input  32  branch instruction address.
REQ-011 SHALL have port ex_target  input  32  computed taken target.
REQ-012 SHALL have port ex_ready  output  1  block accepts ex_valid this cycle.
REQ-013 SHALL have port upd_valid  output  1  predictor update available.
REQ-014 SHALL have port upd_taken  output  1  outcome to train.
REQ-015 SHALL have port upd_pc_bus  output  4  ex_pc[5:2] of the queued branch.
REQ-016 SHALL have port upd_ready  input  1  predictor consumes the update this cycle.
REQ-017 SHALL have port flush  output  1  squash IF/ID and redirect fetch.
REQ-018 SHALL have port redirect_pc  output  32  fetch address after flush.
REQ-019 SHALL have ports br_cnt and mis_cnt  output  CNTW each  resolved-branch and mispredict counts.

Function
REQ-020 SHALL accept an EX entry when ex_valid && ex_ready && rdy ("accept").
REQ-021 SHALL drive ex_ready = 1 only in state RUN with queue not full; no same-cycle full bypass (a dequeue does not free a slot for the same cycle's accept).
REQ-022 SHALL enqueue {ex_taken, ex_pc[5:2]} on accept only when ex_is_btype = 1; non-branch accepts do not enqueue, do not flush, and do not count.
REQ-023 SHALL drive upd_valid = (queue not empty) with upd_taken/upd_pc_bus from the head entry, combinationally from registered state.
REQ-024 SHALL pop the head when upd_valid && upd_ready && rdy; simultaneous push and pop keep count unchanged and preserve FIFO order.
REQ-025 SHALL use wrap-around read/write pointers of log2(QDEPTH) bits and a count of log2(QDEPTH)+1 bits; full at count = QDEPTH, empty at 0.
REQ-026 SHALL implement FSM states RUN and FLUSH; RUN -> FLUSH on accepted branch with ex_taken != ex_pred_taken; FLUSH -> RUN unconditionally after one rdy cycle.
REQ-027 SHALL assert flush = 1 exactly while in FLUSH (one cycle after the mispredicted accept), with redirect_pc registered at accept: ex_target if ex_taken, else ex_pc + 4 (32-bit wrap).
REQ-028 SHALL still enqueue the mispredicted branch's outcome; queue draining continues during FLUSH.
REQ-029 SHALL hold redirect_pc stable outside FLUSH (last value); flush = 0 in RUN.
REQ-030 SHALL increment br_cnt per accepted branch and mis_cnt per accepted mispredict, each saturating at all-ones.
REQ-031 SHALL, with rdy = 0, not accept, not pop, not change state; outputs reflect held state.

Reset
REQ-032 SHALL on rst = 1 at a clock edge: state RUN, pointers and count 0, br_cnt = mis_cnt = 0, redirect_pc = 0; thus flush = 0, upd_valid = 0, ex_ready = 1 next cycle.
REQ-033 SHALL let rst take priority over rdy, accept, pop and FLUSH; reset during FLUSH or with a non-empty queue discards all entries and pending redirect.

Verification
REQ-034 SHALL pass: after reset, 4 correctly-predicted taken branches with upd_ready = 0 -> count 4, ex_ready = 0, 5th ex_valid not accepted, br_cnt = 4, flush never asserted.
REQ-035 SHALL pass: branch at ex_pc 0x1004, ex_taken = 0, ex_pred_taken = 1 -> next cycle flush = 1, redirect_pc = 0x1008, ex_ready = 0 for that cycle, mis_cnt = 1; following cycle flush = 0.
REQ-036 SHALL pass: mispredict ex_taken = 1, ex_target = 0x2000 -> redirect_pc = 0x2000; queued upd_taken = 1, upd_pc_bus = ex_pc[5:2].
REQ-037 SHALL pass: full queue, upd_ready = 1 and ex_valid = 1 same cycle -> pop occurs, no accept, count 3; next cycle accept, count 4; drained order equals enqueue order across pointer wrap (10 entries).
REQ-038 SHALL pass: rdy = 0 for 3 cycles with ex_valid = upd_ready = 1 -> no state change; rst asserted during FLUSH -> flush = 0 and upd_valid = 0 next cycle.
REQ-039 SHALL pass: mis_cnt preloaded near saturation via 2^CNTW+2 mispredicts (CNTW = 4 build) -> mis_cnt holds 0xF.

Source files
------------

// File: rtl/bp_update_sched.sv
// Branch-resolution scheduler: queues predictor training updates from EX,
// raises a one-cycle fetch flush with redirect address on mispredicts, and keeps statistics.
module bp_update_sched #(
  parameter int QDEPTH = 4,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            ex_valid,
  input  logic            ex_is_btype,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pc,
  input  logic [31:0]     ex_target,
  output logic            ex_ready,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [3:0]      upd_pc_bus,
  input  logic            upd_ready,
  output logic            flush,
  output logic [31:0]     redirect_pc,
  output logic [CNTW-1:0] br_cnt,
  output logic [CNTW-1:0] mis_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [4:0]      r_q [QDEPTH];
  logic [31:0]     r_redirect;
  logic [CNTW-1:0] r_br_cnt;
  logic [CNTW-1:0] r_mis_cnt;

  logic w_full;
  logic w_accept;
  logic w_push;
  logic w_mis;
  logic w_pop;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign w_full   = (r_count == FULL_CNT);
  assign w_accept = ex_valid && ex_ready && rdy;
  assign w_push   = w_accept && ex_is_btype;
  assign w_mis    = w_push && (ex_taken != ex_pred_taken);
  assign w_pop    = upd_valid && upd_ready && rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; FLUSH lasts exactly one rdy cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_mis) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (rdy)   w_state_nxt = ST_RUN;
      default:             w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    flush       = (r_state == ST_FLUSH);
    ex_ready    = (r_state == ST_RUN) && !w_full;
    upd_valid   = (r_count != '0);
    upd_taken   = r_q[r_rptr][4];
    upd_pc_bus  = r_q[r_rptr][3:0];
    redirect_pc = r_redirect;
    br_cnt      = r_br_cnt;
    mis_cnt     = r_mis_cnt;
  end

  // Queue control and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_redirect <= '0;
      r_br_cnt   <= '0;
      r_mis_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_push) r_br_cnt <= sat_inc(r_br_cnt);
      if (w_mis) begin
        r_mis_cnt  <= sat_inc(r_mis_cnt);
        r_redirect <= ex_taken ? ex_target : ex_pc + 32'd4;
      end
    end
  end

  // Queue storage carries no reset; validity comes from the count
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= {ex_taken, ex_pc[5:2]};
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_bp_update_sched;

  localparam int QD = 4;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst, rdy, ex_valid, ex_is_btype, ex_taken, ex_pred_taken, upd_ready;
  logic [31:0]   ex_pc, ex_target;
  logic          ex_ready, upd_valid, upd_taken, flush;
  logic [3:0]    upd_pc_bus;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] br_cnt, mis_cnt;

  int checks = 0;
  int errors = 0;

  bit            m_flush = 1'b0;
  logic [4:0]    m_q[$];
  logic [31:0]   m_redir = '0;
  logic [CW-1:0] m_br = '0;
  logic [CW-1:0] m_mis = '0;

  bp_update_sched #(.QDEPTH(QD), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_valid(ex_valid), .ex_is_btype(ex_is_btype), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_ready(ex_ready), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .upd_pc_bus(upd_pc_bus), .upd_ready(upd_ready), .flush(flush),
    .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic v, input logic bt,
                       input logic tk, input logic pt, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic ur);
    rst = r; rdy = rd; ex_valid = v; ex_is_btype = bt; ex_taken = tk;
    ex_pred_taken = pt; ex_pc = pc; ex_target = tgt; upd_ready = ur;
  endtask

  // Behavioural model: one clock edge worth of the stated rules
  task automatic model_step();
    bit acc, pop, can_acc;
    if (rst) begin
      m_flush = 1'b0; m_q.delete(); m_redir = '0; m_br = '0; m_mis = '0;
    end else if (rdy) begin
      can_acc = !m_flush && (m_q.size() < QD);
      acc     = ex_valid && can_acc;
      pop     = (m_q.size() != 0) && upd_ready;
      if (pop) void'(m_q.pop_front());
      m_flush = 1'b0;
      if (acc && ex_is_btype) begin
        m_q.push_back({ex_taken, ex_pc[5:2]});
        if (m_br != CMAX) m_br++;
        if (ex_taken != ex_pred_taken) begin
          m_flush = 1'b1;
          m_redir = ex_taken ? ex_target : ex_pc + 32'd4;
          if (m_mis != CMAX) m_mis++;
        end
      end
    end
  endtask

  task automatic compare();
    chk("ex_ready", ex_ready, (!m_flush && (m_q.size() < QD)));
    chk("upd_valid", upd_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("upd_taken", upd_taken, m_q[0][4]);
      chk("upd_pc_bus", upd_pc_bus, m_q[0][3:0]);
    end
    chk("flush", flush, m_flush);
    chk("redirect_pc", redirect_pc, m_redir);
    chk("br_cnt", br_cnt, m_br);
    chk("mis_cnt", mis_cnt, m_mis);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("reset_ex_ready", ex_ready, 1);
    chk("reset_upd_valid", upd_valid, 0);
    chk("reset_flush", flush, 0);
    chk("reset_redirect", redirect_pc, 0);

    // Fill the queue with correctly predicted taken branches, no draining
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1, 1, 1, 32'h100 + 32'(4 * i), 32'h800, 0);
      tick();
    end
    chk("full_ex_ready", ex_ready, 0);
    chk("full_br_cnt", br_cnt, 4);
    drive(0, 1, 1, 1, 1, 1, 32'h200, 32'h800, 0);
    tick();
    chk("fifth_not_accepted", br_cnt, 4);

    // Pop while full: no same-cycle accept, then accept next cycle
    drive(0, 1, 1, 1, 1, 1, 32'h204, 32'h800, 1);
    tick();
    chk("pop_no_accept_br", br_cnt, 4);
    chk("pop_frees_slot", ex_ready, 1);
    drive(0, 1, 1, 1, 0, 0, 32'h208, 32'h800, 0);
    tick();
    chk("accept_after_pop", br_cnt, 5);
    chk("refull_ex_ready", ex_ready, 0);

    // Stream 10 entries through the queue across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1, i[0], i[0], 32'h300 + 32'(4 * i), 32'h0, 1);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("drained", upd_valid, 0);

    // Not-taken mispredict at 0x1004
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 1, 0, 1, 32'h1004, 32'h4000, 0);
    tick();
    chk("mp_nt_flush", flush, 1);
    chk("mp_nt_redirect", redirect_pc, 32'h1008);
    chk("mp_nt_ex_ready", ex_ready, 0);
    chk("mp_nt_mis_cnt", mis_cnt, 1);
    drive(0, 1, 1, 1, 1, 1, 32'h1010, 32'h0, 0);
    tick();
    chk("mp_nt_flush_end", flush, 0);
    chk("mp_nt_redirect_hold", redirect_pc, 32'h1008);

    // Taken mispredict to 0x2000
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 1, 1, 0, 32'h3034, 32'h2000, 0);
    tick();
    chk("mp_t_redirect", redirect_pc, 32'h2000);
    chk("mp_t_upd_taken", upd_taken, 1);
    chk("mp_t_upd_pc", upd_pc_bus, 4'hD);

    // rdy low: nothing moves
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 32'h50, 32'h0, 1);
      tick();
    end
    chk("stall_flush_held", flush, 1);
    chk("stall_upd_valid", upd_valid, 1);
    chk("stall_br_cnt", br_cnt, 1);

    // Reset during FLUSH
    drive(1, 1, 1, 1, 0, 1, 32'h60, 32'h0, 0);
    tick();
    chk("rst_in_flush_flush", flush, 0);
    chk("rst_in_flush_upd_valid", upd_valid, 0);

    // Drive mispredicts past counter saturation
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      drive(0, 1, 1, 1, 1, 0, 32'h70, 32'h90, 1);
      tick();
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    chk("mis_cnt_saturated", mis_cnt, 4'hF);
    chk("br_cnt_saturated", br_cnt, 4'hF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 75),
            1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 99) < 45));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
